cmd_stream_decoder: RTL and testbench

- Sequential successor of the single-opcode combinational decoder.
- Consumes a byte stream of command opcodes and operand bytes under a valid/ready handshake.
- Per command: decodes the opcode, collects the required operand bytes, and presents one assembled command (one-hot flags, size, packed operands) to the execute stage under a second valid/ready handshake.
- Sits between program memory fetch and the execute unit.

---
 rtl/cmd_stream_decoder_pkg.sv | 40 ++++
 rtl/cmd_stream_decoder_cmd_lut.sv | 35 +++
 rtl/cmd_stream_decoder.sv | 153 +++++++++++++++
 tb/tb_cmd_stream_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_stream_decoder_pkg.sv
// Shared definitions for the command stream decoder and its opcode lookup:
// opcode byte values, one-hot flag bit positions, command sizes and the
// decoder state encoding.
package cmd_stream_decoder_pkg;

  // Opcode byte values (ASCII letters).
  localparam logic [7:0] OP_MOV = 8'h4D;  // 'M'
  localparam logic [7:0] OP_ADD = 8'h41;  // 'A'
  localparam logic [7:0] OP_CMP = 8'h43;  // 'C'
  localparam logic [7:0] OP_JMP = 8'h4A;  // 'J'
  localparam logic [7:0] OP_JEQ = 8'h45;  // 'E'
  localparam logic [7:0] OP_JGG = 8'h47;  // 'G'

  // Bit positions inside the one-hot command flag vector.
  localparam int FLG_MOV = 5;
  localparam int FLG_ADD = 4;
  localparam int FLG_CMP = 3;
  localparam int FLG_JMP = 2;
  localparam int FLG_JEQ = 1;
  localparam int FLG_JGG = 0;

  // Minimum flag vector width that holds every flag above.
  localparam int MIN_FLAGS = 6;

  // Total command length in bytes, opcode included.
  localparam logic [1:0] SZ_MOV = 2'd3;
  localparam logic [1:0] SZ_ADD = 2'd1;
  localparam logic [1:0] SZ_CMP = 2'd1;
  localparam logic [1:0] SZ_JMP = 2'd2;
  localparam logic [1:0] SZ_JEQ = 2'd2;
  localparam logic [1:0] SZ_JGG = 2'd2;

  // Decoder states: waiting for an opcode, gathering operands, presenting.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/cmd_stream_decoder_cmd_lut.sv
// cmd_lut: purely combinational opcode lookup. Maps one opcode byte to its
// one-hot command flag, total command size and a legal indication. Illegal
// opcodes return flags=0, size=0, legal=0. Shared with the disassembler and
// trace tools, so it carries no state.
module cmd_lut
  import cmd_stream_decoder_pkg::*;
#(
  parameter int BYTE_W   = 8,
  parameter int NUM_CMDS = 6
) (
  input  logic [BYTE_W-1:0]   opcode,
  output logic [NUM_CMDS-1:0] flags,
  output logic [1:0]          size,
  output logic                legal
);

  // Table lookup of opcode -> flag, size, legal.
  always_comb begin
    // NOTE: every output gets a default before the case, so no input value
    // leaves an output unassigned and no latch is inferred.
    flags = '0;
    size  = 2'd0;
    legal = 1'b0;
    case (opcode)
      BYTE_W'(OP_MOV): begin flags[FLG_MOV] = 1'b1; size = SZ_MOV; legal = 1'b1; end
      BYTE_W'(OP_ADD): begin flags[FLG_ADD] = 1'b1; size = SZ_ADD; legal = 1'b1; end
      BYTE_W'(OP_CMP): begin flags[FLG_CMP] = 1'b1; size = SZ_CMP; legal = 1'b1; end
      BYTE_W'(OP_JMP): begin flags[FLG_JMP] = 1'b1; size = SZ_JMP; legal = 1'b1; end
      BYTE_W'(OP_JEQ): begin flags[FLG_JEQ] = 1'b1; size = SZ_JEQ; legal = 1'b1; end
      BYTE_W'(OP_JGG): begin flags[FLG_JGG] = 1'b1; size = SZ_JGG; legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/cmd_stream_decoder.sv
// cmd_stream_decoder: turns a byte stream of opcodes and operands into
// assembled commands for the execute stage. One opcode byte is decoded by
// cmd_lut, the required operand bytes are collected, and the finished command
// is held under a valid/ready handshake until the execute stage takes it.
//
// Optional feature macro: CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
//   defined   - an illegal opcode becomes a trap entry (cmd_ill=1, size 1,
//               offending byte in the low operand byte) the execute stage
//               must accept like any other command.
//   undefined - an illegal opcode is consumed and dropped; no cmd_ill port.
module cmd_stream_decoder
  import cmd_stream_decoder_pkg::*;
#(
  parameter int BYTE_W   = 8,
  parameter int MAX_OPS  = 2,
  parameter int NUM_CMDS = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BYTE_W-1:0]         in_byte,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [NUM_CMDS-1:0]       cmd_flgs,
  output logic [1:0]                cmd_size,
  output logic [MAX_OPS*BYTE_W-1:0] cmd_opnd,
  output logic                      cmd_valid,
  input  logic                      cmd_ready
`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
  ,
  output logic                      cmd_ill
`endif
);

  localparam int OPND_W = MAX_OPS * BYTE_W;
  localparam int CNT_W  = $clog2(MAX_OPS + 1);

  // A 3-byte MOV needs two operand slots; the flag vector must hold all flags.
  if (MAX_OPS < 2) begin : g_bad_max_ops
    $error("cmd_stream_decoder: MAX_OPS must be at least 2");
  end
  if (NUM_CMDS < MIN_FLAGS) begin : g_bad_num_cmds
    $error("cmd_stream_decoder: NUM_CMDS too small for the opcode table");
  end

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    slot;
  logic                in_fire;
  logic                cmd_fire;
  logic [NUM_CMDS-1:0] lut_flags;
  logic [1:0]          lut_size;
  logic                lut_legal;

  cmd_lut #(
    .BYTE_W   (BYTE_W),
    .NUM_CMDS (NUM_CMDS)
  ) u_cmd_lut (
    .opcode (in_byte),
    .flags  (lut_flags),
    .size   (lut_size),
    .legal  (lut_legal)
  );

  // Handshake outputs follow the state; in_ready is forced low during reset.
  assign in_ready  = !rst && (state != ST_HOLD);
  assign cmd_valid = (state == ST_HOLD);
  assign in_fire   = in_valid && in_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;

  // Operand slot for the byte arriving now: the first operand goes to slot 0.
  assign slot = CNT_W'(cmd_size) - CNT_W'(1) - cnt;

  // State register; reset discards any partially collected command.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: opcode decode, operand countdown, command handoff.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (in_fire) begin
          if (lut_legal) begin
            state_nxt = (lut_size == 2'd1) ? ST_HOLD : ST_COLLECT;
          end
`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
          else begin
            state_nxt = ST_HOLD;
          end
`endif
        end
      end
      ST_COLLECT: begin
        if (in_fire && (cnt == CNT_W'(1))) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (cmd_fire) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command registers: latch decode on opcode, fill operand slots, hold in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the operand slots are a handful of flops, not a memory, so they
    // are reset together with the rest of the command registers.
    if (rst) begin
      cmd_flgs <= '0;
      cmd_size <= 2'd0;
      cmd_opnd <= '0;
      cnt      <= '0;
    end else if (in_fire) begin
      if (state == ST_IDLE) begin
        if (lut_legal) begin
          cmd_flgs <= lut_flags;
          cmd_size <= lut_size;
          cmd_opnd <= '0;
          cnt      <= CNT_W'(lut_size - 2'd1);
        end
`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
        else begin
          cmd_flgs <= '0;
          cmd_size <= 2'd1;
          cmd_opnd <= OPND_W'(in_byte);
          cnt      <= '0;
        end
`endif
      end else if (state == ST_COLLECT) begin
        for (int i = 0; i < MAX_OPS; i++) begin
          if (slot == CNT_W'(i)) cmd_opnd[i*BYTE_W +: BYTE_W] <= in_byte;
        end
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
  // Trap marker: set by an illegal opcode, cleared by any legal one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ill <= 1'b0;
    end else if (in_fire && (state == ST_IDLE)) begin
      cmd_ill <= !lut_legal;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_stream_decoder.sv
// Testbench for cmd_stream_decoder. Stimulus issues whole commands and pushes
// the expected assembled command into a scoreboard queue; a monitor process
// drives cmd_ready, pops and compares on every command transfer, and checks
// one-hot flags, hold stability and in_ready=0 while a command is presented.
module tb_cmd_stream_decoder;

  localparam int BYTE_W   = 8;
  localparam int MAX_OPS  = 2;
  localparam int NUM_CMDS = 6;
  localparam int OPND_W   = MAX_OPS * BYTE_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [BYTE_W-1:0] in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [NUM_CMDS-1:0] cmd_flgs;
  logic [1:0]        cmd_size;
  logic [OPND_W-1:0] cmd_opnd;
  logic              cmd_valid;
  logic              cmd_ready;
`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
  logic              cmd_ill;
`endif

  always #5 clk = ~clk;

  cmd_stream_decoder #(
    .BYTE_W   (BYTE_W),
    .MAX_OPS  (MAX_OPS),
    .NUM_CMDS (NUM_CMDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cmd_flgs  (cmd_flgs),
    .cmd_size  (cmd_size),
    .cmd_opnd  (cmd_opnd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready)
`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
    ,
    .cmd_ill   (cmd_ill)
`endif
  );

  typedef struct {
    logic [NUM_CMDS-1:0] flags;
    logic [1:0]          size;
    logic [OPND_W-1:0]   opnd;
    logic                ill;
  } exp_t;

  exp_t exp_q[$];
  int   total    = 0;
  int   bad      = 0;
  int   n_pushed = 0;
  int   n_got    = 0;

  // Monitor controls: random ready, or a forced value for directed tests.
  bit   rand_ready  = 1'b0;
  bit   force_ready = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference opcode table: ASCII letter -> command flag and total size.
  function automatic bit ref_decode(input logic [7:0] op,
                                    output logic [NUM_CMDS-1:0] flags,
                                    output int size);
    flags = '0;
    size  = 0;
    case (op)
      8'h4D: begin flags = 6'b100000; size = 3; end  // 'M' MOV
      8'h41: begin flags = 6'b010000; size = 1; end  // 'A' ADD
      8'h43: begin flags = 6'b001000; size = 1; end  // 'C' CMP
      8'h4A: begin flags = 6'b000100; size = 2; end  // 'J' JMP
      8'h45: begin flags = 6'b000010; size = 2; end  // 'E' JEQ
      8'h47: begin flags = 6'b000001; size = 2; end  // 'G' JGG
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Drive one byte after 'gap' idle cycles; returns once it has transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL in_accept_timeout: byte %0h not accepted within 500 cycles", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Issue one command: push its expected result, then stream its bytes.
  task automatic issue(input logic [7:0] op, input logic [15:0] ops, input int gap);
    logic [NUM_CMDS-1:0] f;
    int                  sz;
    exp_t                e;
    if (ref_decode(op, f, sz)) begin
      e.flags = f;
      e.size  = 2'(sz);
      e.opnd  = '0;
      for (int k = 0; k < sz - 1; k++) e.opnd[8*k +: 8] = ops[8*k +: 8];
      e.ill   = 1'b0;
      exp_q.push_back(e);
      n_pushed++;
      send_byte(op, gap);
      for (int k = 0; k < sz - 1; k++) send_byte(ops[8*k +: 8], gap);
    end else begin
`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
      e.flags = '0;
      e.size  = 2'd1;
      e.opnd  = OPND_W'(op);
      e.ill   = 1'b1;
      exp_q.push_back(e);
      n_pushed++;
`endif
      send_byte(op, gap);
    end
  endtask

  // Monitor: checks presented commands, drives cmd_ready, scores transfers.
  initial begin : monitor
    bit                  held = 1'b0;
    logic [NUM_CMDS-1:0] h_flgs;
    logic [1:0]          h_size;
    logic [OPND_W-1:0]   h_opnd;
    exp_t                e;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        check("in_ready_low_in_hold", in_ready, 1'b0);
`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
        if (!cmd_ill) check("flags_onehot", $onehot(cmd_flgs), 1'b1);
`else
        check("flags_onehot", $onehot(cmd_flgs), 1'b1);
`endif
        if (held) begin
          check("hold_flgs", cmd_flgs, h_flgs);
          check("hold_size", cmd_size, h_size);
          check("hold_opnd", cmd_opnd, h_opnd);
        end
      end
      cmd_ready = rand_ready ? ($urandom_range(0, 3) != 0) : force_ready;
      if (cmd_valid && cmd_ready) begin
        held = 1'b0;
        n_got++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cmd: flgs=%b size=%0d opnd=%h with empty scoreboard",
                   cmd_flgs, cmd_size, cmd_opnd);
        end else begin
          e = exp_q.pop_front();
          check("cmd_flgs", cmd_flgs, e.flags);
          check("cmd_size", cmd_size, e.size);
          check("cmd_opnd", cmd_opnd, e.opnd);
`ifdef CMD_STREAM_DECODER_ILLEGAL_TRAP_EN
          check("cmd_ill", cmd_ill, e.ill);
`endif
        end
      end else if (cmd_valid) begin
        held   = 1'b1;
        h_flgs = cmd_flgs;
        h_size = cmd_size;
        h_opnd = cmd_opnd;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed scenarios followed by a random stream.
  initial begin : stim
    logic [7:0] legal_ops [6];
    logic [7:0] op;
    int         n;
    legal_ops[0] = 8'h4D; legal_ops[1] = 8'h41; legal_ops[2] = 8'h43;
    legal_ops[3] = 8'h4A; legal_ops[4] = 8'h45; legal_ops[5] = 8'h47;

    rst       = 1'b1;
    in_byte   = '0;
    in_valid  = 1'b0;
    cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready",  in_ready,  1'b0);
    check("reset_cmd_valid", cmd_valid, 1'b0);
    check("reset_cmd_flgs",  cmd_flgs,  '0);
    check("reset_cmd_size",  cmd_size,  '0);
    check("reset_cmd_opnd",  cmd_opnd,  '0);
    rst = 1'b0;

    // ADD: valid one cycle after the opcode transfers.
    force_ready = 1'b1;
    issue(8'h41, 16'h0000, 0);
    @(negedge clk);
    check("add_latency_valid", cmd_valid, 1'b1);

    // MOV back-to-back: valid right after the third byte transfers.
    issue(8'h4D, 16'h0A05, 0);
    @(negedge clk);
    check("mov_latency_valid", cmd_valid, 1'b1);

    // MOV with 2-cycle input gaps: same result, later.
    issue(8'h4D, 16'h0A05, 2);
    @(negedge clk);
    check("mov_gap_valid", cmd_valid, 1'b1);

    // JMP held by the execute stage for 5 cycles.
    @(posedge clk);
    #1 force_ready = 1'b0;
    issue(8'h4A, 16'h0010, 0);
    @(negedge clk);
    check("jmp_valid", cmd_valid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("jmp_stall_in_ready", in_ready, 1'b0);
      check("jmp_stall_valid", cmd_valid, 1'b1);
    end
    @(posedge clk);
    #1 force_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("jmp_release_in_ready", in_ready, 1'b1);
    check("jmp_release_valid", cmd_valid, 1'b0);

    // Illegal opcode followed by CMP.
    issue(8'h00, 16'h0000, 0);
    issue(8'h43, 16'h0000, 0);

    // Reset in the middle of a MOV: the partial command is discarded.
    repeat (3) @(negedge clk);
    send_byte(8'h4D, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready",  in_ready,  1'b0);
    check("midrst_cmd_valid", cmd_valid, 1'b0);
    check("midrst_cmd_flgs",  cmd_flgs,  '0);
    check("midrst_cmd_opnd",  cmd_opnd,  '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(8'h45, 16'h0007, 0);
    @(negedge clk);
    check("jeq_after_reset_valid", cmd_valid, 1'b1);

    // Random legal/illegal stream with random ready stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 5)];
      else                          op = 8'($urandom);
      issue(op, 16'($urandom), $urandom_range(0, 2));
    end

    // Drain the scoreboard.
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("cmd_count", n_got, n_pushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
